// File: rtl/tmds_word_aligner.sv
// rtl/tmds_word_aligner.sv - TMDS 10-bit symbol boundary recovery with lock tracking
module tmds_word_aligner #(
   parameter int LOCK_RUN       = 8,
   parameter int SEARCH_TIMEOUT = 4096,
   parameter int LOSS_TIMEOUT   = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] tmds_in,
   output logic [9:0] tmds_out,
   output logic       locked,
   output logic [3:0] offset
);

   localparam int TMAX = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
   localparam int TW   = $clog2(TMAX) + 1;
   localparam int RW   = $clog2(LOCK_RUN + 1);

   typedef enum logic [1:0] {
      S_SEARCH = 2'd0,
      S_SLIP   = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [9:0]      r_prev;
   logic [9:0]      r_out;
   logic [3:0]      r_offset, w_offset_nxt;
   logic [TW-1:0]   r_timer, w_timer_nxt;
   logic [RW-1:0]   r_run, w_run_nxt;
   logic            r_slip, w_slip_nxt;

   // The top bit of the current word is only ever needed one cycle later, via r_prev.
   logic [18:0]     w_cat;
   logic [9:0]      w_win;
   logic            w_hit;
   logic [3:0]      w_offset_inc;

   assign w_cat        = {tmds_in[8:0], r_prev};
   assign w_offset_inc = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;

   always_comb begin
      w_win = w_cat[9:0];
      case (r_offset)
         4'd0:    w_win = w_cat[9:0];
         4'd1:    w_win = w_cat[10:1];
         4'd2:    w_win = w_cat[11:2];
         4'd3:    w_win = w_cat[12:3];
         4'd4:    w_win = w_cat[13:4];
         4'd5:    w_win = w_cat[14:5];
         4'd6:    w_win = w_cat[15:6];
         4'd7:    w_win = w_cat[16:7];
         4'd8:    w_win = w_cat[17:8];
         4'd9:    w_win = w_cat[18:9];
         default: w_win = w_cat[9:0];
      endcase
   end

   assign w_hit = (r_out == 10'b1101010100) || (r_out == 10'b0010101011) ||
                  (r_out == 10'b0101010100) || (r_out == 10'b1010101011);

   always_comb begin
      w_state_nxt  = r_state;
      w_offset_nxt = r_offset;
      w_timer_nxt  = r_timer;
      w_slip_nxt   = 1'b0;
      if (!w_hit) begin
         w_run_nxt = '0;
      end else if (r_run == RW'(LOCK_RUN)) begin
         w_run_nxt = r_run;
      end else begin
         w_run_nxt = r_run + 1'b1;
      end

      case (r_state)
         S_SEARCH: begin
            w_timer_nxt = r_timer + 1'b1;
            if (w_hit && (r_run == RW'(LOCK_RUN - 1))) begin
               w_state_nxt = S_LOCKED;
               w_timer_nxt = '0;
            end else if (r_timer == TW'(SEARCH_TIMEOUT - 1)) begin
               w_state_nxt  = S_SLIP;
               w_timer_nxt  = '0;
               w_offset_nxt = w_offset_inc;
            end
         end
         S_SLIP: begin
            // Words still in flight from the old offset must not count toward a run.
            w_run_nxt   = '0;
            w_timer_nxt = '0;
            w_slip_nxt  = ~r_slip;
            if (r_slip) begin
               w_state_nxt = S_SEARCH;
            end
         end
         S_LOCKED: begin
            if (!w_hit && (r_timer == TW'(LOSS_TIMEOUT - 1))) begin
               w_state_nxt  = S_SLIP;
               w_timer_nxt  = '0;
               w_offset_nxt = w_offset_inc;
            end else if (w_hit) begin
               w_timer_nxt = '0;
            end else begin
               w_timer_nxt = r_timer + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_SEARCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_SEARCH;
         r_prev   <= '0;
         r_out    <= '0;
         r_offset <= '0;
         r_timer  <= '0;
         r_run    <= '0;
         r_slip   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_prev   <= tmds_in;
         r_out    <= w_win;
         r_offset <= w_offset_nxt;
         r_timer  <= w_timer_nxt;
         r_run    <= w_run_nxt;
         r_slip   <= w_slip_nxt;
      end
   end

   assign tmds_out = r_out;
   assign locked   = (r_state == S_LOCKED);
   assign offset   = r_offset;

endmodule
